// File: rtl/cpu_sequencer.sv
// rtl/cpu_sequencer.sv - eight-phase VeriRISC control sequencer
module cpu_sequencer #(
    parameter int HALT_STICKY = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] opcode,
    input  logic       zero,
    output logic       sel,
    output logic       rd,
    output logic       ld_ir,
    output logic       inc_pc,
    output logic       halt,
    output logic       ld_pc,
    output logic       data_e,
    output logic       ld_ac,
    output logic       wr,
    output logic [2:0] phase
);

    typedef enum logic [2:0] {
        INST_ADDR  = 3'd0,
        INST_FETCH = 3'd1,
        INST_LOAD  = 3'd2,
        IDLE       = 3'd3,
        OP_ADDR    = 3'd4,
        OP_FETCH   = 3'd5,
        ALU_OP     = 3'd6,
        STORE      = 3'd7
    } phase_t;

    localparam logic [2:0] OPC_HLT = 3'b000;
    localparam logic [2:0] OPC_SKZ = 3'b001;
    localparam logic [2:0] OPC_ADD = 3'b010;
    localparam logic [2:0] OPC_AND = 3'b011;
    localparam logic [2:0] OPC_XOR = 3'b100;
    localparam logic [2:0] OPC_LDA = 3'b101;
    localparam logic [2:0] OPC_STO = 3'b110;
    localparam logic [2:0] OPC_JMP = 3'b111;

    phase_t r_phase;
    logic   r_halted;

    logic w_aluop;
    logic w_sel, w_rd, w_ld_ir, w_inc_pc, w_halt, w_ld_pc, w_data_e, w_ld_ac, w_wr;

    // A sticky halt freezes the phase at OP_ADDR instead of advancing.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_phase  <= INST_ADDR;
            r_halted <= 1'b0;
        end else if (!r_halted) begin
            if (HALT_STICKY != 0 && r_phase == OP_ADDR && opcode == OPC_HLT) begin
                r_halted <= 1'b1;
            end else begin
                r_phase <= phase_t'(r_phase + 3'd1);
            end
        end
    end

    assign w_aluop = (opcode == OPC_ADD) || (opcode == OPC_AND) ||
                     (opcode == OPC_XOR) || (opcode == OPC_LDA);

    always_comb begin
        w_sel    = 1'b0;
        w_rd     = 1'b0;
        w_ld_ir  = 1'b0;
        w_inc_pc = 1'b0;
        w_halt   = 1'b0;
        w_ld_pc  = 1'b0;
        w_data_e = 1'b0;
        w_ld_ac  = 1'b0;
        w_wr     = 1'b0;
        if (r_halted) begin
            w_halt = 1'b1;
        end else begin
            case (r_phase)
                INST_ADDR: begin
                    w_sel = 1'b1;
                end
                INST_FETCH: begin
                    w_sel = 1'b1;
                    w_rd  = 1'b1;
                end
                INST_LOAD, IDLE: begin
                    w_sel   = 1'b1;
                    w_rd    = 1'b1;
                    w_ld_ir = 1'b1;
                end
                OP_ADDR: begin
                    w_inc_pc = 1'b1;
                    w_halt   = (opcode == OPC_HLT);
                end
                OP_FETCH: begin
                    w_rd = w_aluop;
                end
                ALU_OP: begin
                    w_rd     = w_aluop;
                    w_inc_pc = (opcode == OPC_SKZ) && zero;
                    w_ld_pc  = (opcode == OPC_JMP);
                    w_data_e = (opcode == OPC_STO);
                end
                STORE: begin
                    w_rd     = w_aluop;
                    w_inc_pc = (opcode == OPC_JMP);
                    w_ld_pc  = (opcode == OPC_JMP);
                    w_ld_ac  = w_aluop;
                    w_wr     = (opcode == OPC_STO);
                    w_data_e = (opcode == OPC_STO);
                end
                default: ;
            endcase
        end
    end

    assign sel    = w_sel;
    assign rd     = w_rd;
    assign ld_ir  = w_ld_ir;
    assign inc_pc = w_inc_pc;
    assign halt   = w_halt;
    assign ld_pc  = w_ld_pc;
    assign data_e = w_data_e;
    assign ld_ac  = w_ld_ac;
    assign wr     = w_wr;
    assign phase  = r_phase;

endmodule

// File: tb/tb_cpu_sequencer.sv
// tb/tb_cpu_sequencer.sv - scoreboard bench for cpu_sequencer, sticky and pulsed halt
module tb_cpu_sequencer;

    logic       clk;
    logic       rst;
    logic [2:0] opcode;
    logic       zero;

    logic       s_sel, s_rd, s_ld_ir, s_inc_pc, s_halt, s_ld_pc, s_data_e, s_ld_ac, s_wr;
    logic [2:0] s_phase;
    logic       p_sel, p_rd, p_ld_ir, p_inc_pc, p_halt, p_ld_pc, p_data_e, p_ld_ac, p_wr;
    logic [2:0] p_phase;

    int total = 0;
    int bad   = 0;

    logic [11:0] sb_q[$];

    int   m_phase_s, m_phase_p;
    logic m_halted_s;

    cpu_sequencer #(.HALT_STICKY(1)) u_dut_sticky (
        .clk(clk), .rst(rst), .opcode(opcode), .zero(zero),
        .sel(s_sel), .rd(s_rd), .ld_ir(s_ld_ir), .inc_pc(s_inc_pc), .halt(s_halt),
        .ld_pc(s_ld_pc), .data_e(s_data_e), .ld_ac(s_ld_ac), .wr(s_wr), .phase(s_phase)
    );

    cpu_sequencer #(.HALT_STICKY(0)) u_dut_pulse (
        .clk(clk), .rst(rst), .opcode(opcode), .zero(zero),
        .sel(p_sel), .rd(p_rd), .ld_ir(p_ld_ir), .inc_pc(p_inc_pc), .halt(p_halt),
        .ld_pc(p_ld_pc), .data_e(p_data_e), .ld_ac(p_ld_ac), .wr(p_wr), .phase(p_phase)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Packing: {phase, sel, rd, ld_ir, inc_pc, halt, ld_pc, data_e, ld_ac, wr}
    function automatic logic [11:0] model(int ph, logic halted, logic [2:0] op, logic z);
        logic aluop, e_sel, e_rd, e_ld_ir, e_inc, e_halt, e_ld_pc, e_de, e_ld_ac, e_wr;
        aluop = (op == 3'd2) || (op == 3'd3) || (op == 3'd4) || (op == 3'd5);
        if (halted) return {3'd4, 9'b0000_1_0000};
        e_sel   = (ph < 4);
        e_rd    = (ph >= 1 && ph <= 3) || (ph >= 5 && aluop);
        e_ld_ir = (ph == 2) || (ph == 3);
        e_inc   = (ph == 4) || (ph == 6 && op == 3'd1 && z) || (ph == 7 && op == 3'd7);
        e_halt  = (ph == 4) && (op == 3'd0);
        e_ld_pc = (ph == 6 || ph == 7) && (op == 3'd7);
        e_de    = (ph == 6 || ph == 7) && (op == 3'd6);
        e_ld_ac = (ph == 7) && aluop;
        e_wr    = (ph == 7) && (op == 3'd6);
        return {ph[2:0], e_sel, e_rd, e_ld_ir, e_inc, e_halt, e_ld_pc, e_de, e_ld_ac, e_wr};
    endfunction

    task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %03h want %03h", tag, obs, exp);
        end
    endtask

    task automatic push_expected();
        sb_q.push_back(model(m_phase_s, m_halted_s, opcode, zero));
        sb_q.push_back(model(m_phase_p, 1'b0, opcode, zero));
    endtask

    task automatic compare(input string tag);
        logic [11:0] exp_s, exp_p;
        exp_s = sb_q.pop_front();
        exp_p = sb_q.pop_front();
        check({tag, "/sticky"},
              {s_phase, s_sel, s_rd, s_ld_ir, s_inc_pc, s_halt, s_ld_pc, s_data_e, s_ld_ac, s_wr}, exp_s);
        check({tag, "/pulse"},
              {p_phase, p_sel, p_rd, p_ld_ir, p_inc_pc, p_halt, p_ld_pc, p_data_e, p_ld_ac, p_wr}, exp_p);
    endtask

    task automatic model_reset();
        m_phase_s  = 0;
        m_phase_p  = 0;
        m_halted_s = 1'b0;
    endtask

    // One clock: drive, score, then advance the models across the edge.
    task automatic step(input string tag, input logic [2:0] op, input logic z);
        opcode = op;
        zero   = z;
        push_expected();
        #1;
        compare(tag);
        @(posedge clk);
        #1;
        if (!m_halted_s) begin
            if (m_phase_s == 4 && op == 3'd0) m_halted_s = 1'b1;
            else m_phase_s = (m_phase_s + 1) % 8;
        end
        m_phase_p = (m_phase_p + 1) % 8;
    endtask

    // Opcode in phases 0-3 is scrambled; it must not influence those strobes.
    task automatic run_instr(input string tag, input logic [2:0] op, input logic [7:0] zpat);
        for (int i = 0; i < 8; i++) begin
            if (i < 4) step(tag, 3'($urandom_range(0, 7)), zpat[i]);
            else       step(tag, op, zpat[i]);
        end
    endtask

    initial begin
        rst    = 1'b1;
        opcode = 3'd0;
        zero   = 1'b0;
        model_reset();
        #2;
        push_expected();
        compare("reset_init");
        @(posedge clk);
        #1;
        rst = 1'b0;

        run_instr("add_z0", 3'd2, 8'h00);
        run_instr("add_z1", 3'd2, 8'hFF);

        for (int i = 0; i < 5; i++) step("pre_rst", 3'd2, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        push_expected();
        compare("async_rst");
        #2;
        rst = 1'b0;

        run_instr("add_after_rst", 3'd2, 8'h00);
        run_instr("skz_z1", 3'd1, 8'hFF);
        run_instr("skz_z0", 3'd1, 8'h00);
        run_instr("skz_ztog5", 3'd1, 8'h20);
        run_instr("skz_z6only", 3'd1, 8'h40);
        run_instr("and", 3'd3, 8'h5A);
        run_instr("xor", 3'd4, 8'hA5);
        run_instr("lda", 3'd5, 8'h0F);
        run_instr("sto", 3'd6, 8'hFF);
        run_instr("jmp", 3'd7, 8'h00);

        run_instr("hlt", 3'd0, 8'h00);
        for (int i = 0; i < 20; i++) step("hlt_hold", 3'd0, i[0]);
        for (int i = 0; i < 20; i++) step("hlt_hold_add", 3'd2, 1'b1);

        #2;
        rst = 1'b1;
        #1;
        model_reset();
        push_expected();
        compare("hlt_rst");
        #2;
        rst = 1'b0;
        run_instr("add_after_hlt", 3'd2, 8'h00);
        run_instr("sto_after_hlt", 3'd6, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
